rom_arbiter: RTL

- Shares the single synchronous-read ROM port between two requesters: the instruction fetch unit (port I) and the load unit (port D).
- Sequences each access: issue address/size/enable, capture the misaligned-access exception, return one-cycle acknowledge with data.
- Round-robin arbitration under contention. Sits between the CPU front-end/LSU and the ROM.

---
 rtl/rom_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
// Two-port (fetch/load) arbiter in front of a single synchronous-read ROM port.
// One access in flight at a time; round-robin only when both ports contend.
module rom_arbiter #(
  parameter int SIZE = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            i_req,
  input  logic [SIZE+2:0] i_addr,
  output logic            i_ack,
  output logic [31:0]     i_rdata,
  output logic            i_err,
  input  logic            d_req,
  input  logic [SIZE+2:0] d_addr,
  input  logic [2:0]      d_size,
  output logic            d_ack,
  output logic [31:0]     d_rdata,
  output logic            d_err,
  output logic [SIZE+2:0] rom_addr,
  output logic [2:0]      rom_size,
  output logic            rom_en,
  input  logic [31:0]     rom_data,
  input  logic            rom_exc
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  state_t state;
  port_t  last_grant;
  port_t  owner;
  logic   exc_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      last_grant <= PORT_D;
      owner      <= PORT_I;
      exc_q      <= 1'b0;
      i_ack      <= 1'b0;
      i_rdata    <= '0;
      i_err      <= 1'b0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
      rom_addr   <= '0;
      rom_size   <= '0;
      rom_en     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          // Under contention the port that did not win last time goes first.
          if (i_req && (!d_req || last_grant == PORT_D)) begin
            rom_addr <= i_addr;
            rom_size <= 3'b010;
            rom_en   <= 1'b1;
            owner    <= PORT_I;
            if (d_req) last_grant <= PORT_I;
            state    <= ISSUE;
          end else if (d_req) begin
            rom_addr <= d_addr;
            rom_size <= d_size;
            rom_en   <= 1'b1;
            owner    <= PORT_D;
            if (i_req) last_grant <= PORT_D;
            state    <= ISSUE;
          end else begin
            rom_en <= 1'b0;
          end
        end
        ISSUE: begin
          // ROM samples addr/size on this edge; its exception is combinational now.
          exc_q <= rom_exc;
          state <= RESP;
        end
        RESP: begin
          if (owner == PORT_I) begin
            i_ack   <= 1'b1;
            i_rdata <= exc_q ? 32'h0 : rom_data;
            i_err   <= exc_q;
          end else begin
            d_ack   <= 1'b1;
            d_rdata <= exc_q ? 32'h0 : rom_data;
            d_err   <= exc_q;
          end
          rom_en <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
